encoder_32t5_seq: RTL and testbench
===================================

Name: encoder_32t5_seq

Overview:
- Sequential 32-to-5 encoder. It is the inverse of the codebase's 5-to-32 decoder.
- Accepts a 32-bit multi-hot vector (e.g. register-file pending/write-enable bits) through a valid/ready handshake.
- Emits the 5-bit index of every set bit, one per output handshake, in priority order.
- Sits between hazard/pending-bit logic and any consumer that needs register numbers serially (register scrub, debug dump).

Parameters:
- WIDTH, 32, input vector width; must be a power of two.
- IDX_W, 5, index width; must equal log2(WIDTH).
- LSB_FIRST, 1, 1 = lowest set index emitted first; 0 = highest set index first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  multi-hot vector to encode
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer takes the current index
- out_idx  output  IDX_W  index of the current selected bit
- out_last  output  1  current beat is the final beat for this vector
- out_none  output  1  accepted vector was all-zero; this beat carries no index
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- State register: IDLE or EMIT. Internal registers:
  - pending[WIDTH-1:0]: bits still to emit.
  - none_flag: the accepted vector was zero.
- Reset (rst_n=0 at a clk edge, any state, including mid-EMIT):
  - state=IDLE, pending=0, none_flag=0.
  - Outputs after that edge: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0.
  - Reset takes priority over every handshake in the same cycle.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: pending<=in_vec, none_flag<=(in_vec==0), state<=EMIT.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - in_valid is ignored; the source must hold.
- Output decode (combinational from registered state; no input-to-output combinational path):
  - out_idx = lowest set bit of pending if LSB_FIRST=1, else highest set bit. out_idx=0 when out_none=1.
  - out_last = 1 when pending has exactly one bit set, or when none_flag=1.
  - out_none = none_flag.
- Beat consumed (out_valid & out_ready):
  - Clear bit out_idx in pending.
  - If out_last=1: none_flag<=0, state<=IDLE.
  - Otherwise stay in EMIT; the next index is presented in the next cycle.
- out_valid=1 and out_ready=0: out_idx, out_last and out_none hold stable until taken.
- Latency and throughput:
  - First index is valid one cycle after the input handshake.
  - One index per cycle while out_ready=1.
  - in_ready returns 1 the cycle after the last beat is taken.
  - A vector with k set bits costs max(k,1)+1 cycles at full throughput.
- Boundary cases:
  - All-zero vector: exactly one beat with out_none=1, out_last=1, out_idx=0.
  - All-ones vector: 32 beats; indices 0..31 (LSB_FIRST=1) or 31..0 (LSB_FIRST=0); out_last only on the 32nd.
  - Bit 31 alone: one beat, out_idx=31, out_last=1.
- Round-trip invariant: for any one-hot input, out_idx fed back through decoder_5t32 reproduces in_vec.

Test Plan:
- Reset, then in_vec=32'h0000_0001 with out_ready=1 -> one beat, out_idx=0, out_last=1; in_ready=1 on the following cycle.
- in_vec=32'h8000_0011, LSB_FIRST=1, out_ready=1 -> out_idx sequence 0,4,31; out_last only on 31; 4 total cycles from accept to in_ready=1.
- Same vector with out_ready toggling 1,0,0,1,1 -> out_idx held stable through stalls; sequence still 0,4,31; in_valid pulses during EMIT are ignored.
- in_vec=32'h0 -> single beat with out_none=1, out_last=1, out_idx=0; then back to IDLE.
- in_vec=32'hFFFF_FFFF, LSB_FIRST=0 -> 32 beats with indices 31 down to 0; each index decoded through decoder_5t32 matches one bit of the input exactly once.
- Reset mid-operation: after 2 beats of 32'hFFFF_FFFF, drive rst_n=0 for one edge -> out_valid=0, in_ready=1, pending cleared; a new vector 32'h0000_0100 then yields only index 8.

Source files
------------

// File: rtl/encoder_32t5_seq_if.sv
// Handshake bundle for the sequential 32-to-5 encoder: vector in, index stream out.
interface encoder_32t5_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;

  // Producer of vectors / consumer of indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/encoder_32t5_seq.sv
// Sequential 32-to-5 encoder: accepts a multi-hot vector and emits the index
// of every set bit, one per output handshake, in priority order.
module encoder_32t5_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_W     = 5,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  encoder_32t5_seq_if.slave  bus,
  output logic               busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pending, pending_nx;
  logic             none_flag, none_nx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             sel_last;
  logic [WIDTH-1:0] clr_mask;

  // State and working registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      none_flag <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      none_flag <= none_nx;
    end
  end

  // Priority select over pending: first set bit scanning from the preferred end.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!sel_found && pending[LSB_FIRST ? i : (WIDTH - 1 - i)]) begin
        sel_idx   = IDX_W'(LSB_FIRST ? i : (WIDTH - 1 - i));
        sel_found = 1'b1;
      end
    end
    clr_mask          = '0;
    clr_mask[sel_idx] = 1'b1;
    sel_last = none_flag ||
               ((pending != '0) && ((pending & (pending - WIDTH'(1))) == '0));
  end

  // Next-state: load on input handshake, retire one bit per output handshake.
  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    none_nx    = none_flag;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          pending_nx = bus.in_vec;
          none_nx    = (bus.in_vec == '0);
          state_nx   = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_nx = pending & ~clr_mask;
          if (sel_last) begin
            none_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == EMIT);
    busy          = (state == EMIT);
    bus.out_idx   = none_flag ? '0 : sel_idx;
    bus.out_last  = sel_last;
    bus.out_none  = none_flag;
  end

endmodule

// File: tb/tb_encoder_32t5_seq.sv
// Directed bench for encoder_32t5_seq: one LSB-first and one MSB-first instance.
module tb_encoder_32t5_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dsel = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [31:0] drv_vec = '0;
  logic        busy0, busy1;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  encoder_32t5_seq_if #(.WIDTH(32), .IDX_W(5)) if0 ();
  encoder_32t5_seq_if #(.WIDTH(32), .IDX_W(5)) if1 ();

  encoder_32t5_seq #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0)
  );
  encoder_32t5_seq #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1)
  );

  assign if0.in_valid  = drv_valid & ~dsel;
  assign if1.in_valid  = drv_valid & dsel;
  assign if0.in_vec    = drv_vec;
  assign if1.in_vec    = drv_vec;
  assign if0.out_ready = drv_ready & ~dsel;
  assign if1.out_ready = drv_ready & dsel;

  logic       mo_ready, mo_valid, mo_last, mo_none, mo_busy;
  logic [4:0] mo_idx;
  assign mo_ready = dsel ? if1.in_ready  : if0.in_ready;
  assign mo_valid = dsel ? if1.out_valid : if0.out_valid;
  assign mo_last  = dsel ? if1.out_last  : if0.out_last;
  assign mo_none  = dsel ? if1.out_none  : if0.out_none;
  assign mo_idx   = dsel ? if1.out_idx   : if0.out_idx;
  assign mo_busy  = dsel ? busy1         : busy0;

  typedef struct {
    logic [31:0] vec;
    int unsigned n;
    logic [4:0]  idx [4];
    logic        none;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int unsigned r, input logic [31:0] v, input int unsigned n,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [4:0] d, input logic none);
    tbl[r].vec    = v;
    tbl[r].n      = n;
    tbl[r].idx[0] = a;
    tbl[r].idx[1] = b;
    tbl[r].idx[2] = c;
    tbl[r].idx[3] = d;
    tbl[r].none   = none;
  endtask

  task automatic accept(input logic [31:0] v);
    int unsigned w = 0;
    while (!mo_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_wait", {31'b0, mo_ready}, 32'd1);
    drv_vec   = v;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'b0, mo_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'b0, mo_ready}, 32'd1);
    check({tag, "_busy"},      {31'b0, mo_busy},  32'd0);
  endtask

  initial begin
    int unsigned e;
    logic [31:0] seen, dec;

    set_row(0, 32'h0000_0001, 1, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0);
    set_row(1, 32'h8000_0011, 3, 5'd0,  5'd4,  5'd31, 5'd0,  1'b0);
    set_row(2, 32'h0000_0000, 1, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1);
    set_row(3, 32'h8000_0000, 1, 5'd31, 5'd0,  5'd0,  5'd0,  1'b0);
    set_row(4, 32'h0000_0100, 1, 5'd8,  5'd0,  5'd0,  5'd0,  1'b0);
    set_row(5, 32'h0000_A005, 4, 5'd0,  5'd2,  5'd13, 5'd15, 1'b0);
    set_row(6, 32'h4000_0002, 2, 5'd1,  5'd30, 5'd0,  5'd0,  1'b0);

    // Reset state on both instances.
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      #1;
      check_idle("rst");
      check("rst_idx",  {27'b0, mo_idx}, 32'd0);
      check("rst_last", {31'b0, mo_last}, 32'd0);
      check("rst_none", {31'b0, mo_none}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Table: each row on the LSB-first then MSB-first instance, full throughput.
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int unsigned r = 0; r < 7; r++) begin
        accept(tbl[r].vec);
        drv_ready = 1'b1;
        for (int unsigned b = 0; b < tbl[r].n; b++) begin
          e = (d == 1) ? 32'(tbl[r].idx[tbl[r].n - 1 - b]) : 32'(tbl[r].idx[b]);
          check($sformatf("d%0d_r%0d_b%0d_valid", d, r, b), {31'b0, mo_valid}, 32'd1);
          check($sformatf("d%0d_r%0d_b%0d_idx", d, r, b), {27'b0, mo_idx}, e);
          check($sformatf("d%0d_r%0d_b%0d_last", d, r, b), {31'b0, mo_last},
                {31'b0, (b == tbl[r].n - 1)});
          check($sformatf("d%0d_r%0d_b%0d_none", d, r, b), {31'b0, mo_none}, {31'b0, tbl[r].none});
          check($sformatf("d%0d_r%0d_b%0d_busy", d, r, b), {31'b0, mo_busy}, 32'd1);
          tick();
        end
        drv_ready = 1'b0;
        check_idle($sformatf("d%0d_r%0d_done", d, r));
      end
    end

    // Stalls with out_ready 1,0,0,1,1 and an in_valid pulse during EMIT.
    dsel = 1'b0;
    accept(32'h8000_0011);
    drv_ready = 1'b1;
    check("stall_idx0", {27'b0, mo_idx}, 32'd0);
    tick();
    drv_ready = 1'b0;
    check("stall_idx4a", {27'b0, mo_idx}, 32'd4);
    tick();
    check("stall_idx4b", {27'b0, mo_idx}, 32'd4);
    check("stall_last4b", {31'b0, mo_last}, 32'd0);
    check("stall_in_ready", {31'b0, mo_ready}, 32'd0);
    drv_vec   = 32'h0000_FFFF;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    check("stall_idx4c", {27'b0, mo_idx}, 32'd4);
    check("stall_valid4c", {31'b0, mo_valid}, 32'd1);
    drv_ready = 1'b1;
    tick();
    check("stall_idx31", {27'b0, mo_idx}, 32'd31);
    check("stall_last31", {31'b0, mo_last}, 32'd1);
    tick();
    drv_ready = 1'b0;
    check_idle("stall_done");
    tick();
    check("stall_no_reload", {31'b0, mo_valid}, 32'd0);

    // All-ones on both instances, indices decoded back to one-hot.
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      seen = '0;
      accept(32'hFFFF_FFFF);
      drv_ready = 1'b1;
      for (int unsigned b = 0; b < 32; b++) begin
        e = (d == 1) ? (31 - b) : b;
        check($sformatf("ones_d%0d_b%0d_idx", d, b), {27'b0, mo_idx}, e);
        check($sformatf("ones_d%0d_b%0d_last", d, b), {31'b0, mo_last}, {31'b0, (b == 31)});
        dec = 32'd1 << mo_idx;
        check($sformatf("ones_d%0d_b%0d_dup", d, b), seen & dec, 32'd0);
        seen = seen | dec;
        tick();
      end
      drv_ready = 1'b0;
      check($sformatf("ones_d%0d_cover", d), seen, 32'hFFFF_FFFF);
      check_idle($sformatf("ones_d%0d_done", d));
    end

    // Reset mid-EMIT beats a concurrent handshake; then a fresh vector.
    dsel = 1'b0;
    accept(32'hFFFF_FFFF);
    drv_ready = 1'b1;
    check("mid_idx0", {27'b0, mo_idx}, 32'd0);
    tick();
    check("mid_idx1", {27'b0, mo_idx}, 32'd1);
    tick();
    rst_n     = 1'b0;
    drv_valid = 1'b1;
    drv_vec   = 32'h0000_0005;
    tick();
    rst_n     = 1'b1;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_idx",  {27'b0, mo_idx}, 32'd0);
    check("mid_rst_last", {31'b0, mo_last}, 32'd0);
    tick();
    check("mid_rst_stay", {31'b0, mo_valid}, 32'd0);
    accept(32'h0000_0100);
    drv_ready = 1'b1;
    check("mid_new_idx", {27'b0, mo_idx}, 32'd8);
    check("mid_new_last", {31'b0, mo_last}, 32'd1);
    tick();
    drv_ready = 1'b0;
    check_idle("mid_new_done");

    // Reset while holding a zero vector clears the none flag.
    accept(32'h0000_0000);
    check("zrst_none_before", {31'b0, mo_none}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("zrst_none_after", {31'b0, mo_none}, 32'd0);
    check("zrst_last_after", {31'b0, mo_last}, 32'd0);
    check_idle("zrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
